// File: rtl/chien_search_param.sv
// Chien search for RS(N,K) over GF(2^M): walks positions N-1..0,
// flags roots of Lambda(alpha^-p) and streams the odd-term sum.
// Ports:
//   clk_in, sys_rst        clock, synchronous active-high reset
//   start                  load lambda_in/lambda_deg when idle
//   lambda_in[(T+1)*M]     coefficient i at [i*M +: M]
//   lambda_deg[CW]         degree reported by Berlekamp-Massey
//   busy                   frame in progress
//   out_valid/pos/err/lodd per-position result stream
//   done                   one-cycle end-of-frame pulse
//   err_cnt, fail          frame summary, held until next frame ends
module chien_search_param #(
   parameter int         M         = 8,
   parameter int         T         = 8,
   parameter int         N         = 255,
   parameter logic [M:0] PRIM_POLY = 9'h11D,
   parameter int         PW        = $clog2(N),
   parameter int         CW        = $clog2(T + 1)
) (
   input  logic                 clk_in,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [(T+1)*M-1:0]   lambda_in,
   input  logic [CW-1:0]        lambda_deg,
   output logic                 busy,
   output logic                 out_valid,
   output logic [PW-1:0]        out_pos,
   output logic                 out_err,
   output logic [M-1:0]         out_lodd,
   output logic                 done,
   output logic [CW-1:0]        err_cnt,
   output logic                 fail
);

   localparam int Q = (1 << M) - 1;

   typedef logic [T:0][M-1:0] tab_t;

   function automatic logic [M-1:0] xtime(input logic [M-1:0] x);
      logic [M-1:0] r;
      r = {x[M-2:0], 1'b0};
      if (x[M-1]) r = r ^ PRIM_POLY[M-1:0];
      return r;
   endfunction

   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                           input logic [M-1:0] b);
      logic [M-1:0] p;
      p = '0;
      for (int k = M - 1; k >= 0; k--) begin
         p = xtime(p);
         if (b[k]) p = p ^ a;
      end
      return p;
   endfunction

   // square-and-multiply keeps elaboration-time loops short
   function automatic logic [M-1:0] gf_pow(input int e);
      logic [M-1:0] r;
      logic [M-1:0] b;
      int           k;
      k = e % Q;
      r = M'(1);
      b = M'(2);
      for (int j = 0; j < 32; j++) begin
         if (k[j]) r = gf_mul(r, b);
         b = gf_mul(b, b);
      end
      return r;
   endfunction

   function automatic tab_t mk_tab(input int base);
      tab_t t;
      for (int i = 0; i <= T; i++) t[i] = gf_pow(i * base);
      return t;
   endfunction

   // load scaling makes the first evaluation land on position N-1
   localparam tab_t K_LOAD = mk_tab(Q - N + 1);
   localparam tab_t K_STEP = mk_tab(1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   tab_t            term_q;
   tab_t            lam_w;
   logic [PW-1:0]   pos_q;
   logic [CW-1:0]   acc_q;
   logic [CW-1:0]   deg_q;
   logic [M-1:0]    sum;
   logic [M-1:0]    lodd;
   logic            load;
   logic            run;

   assign lam_w = lambda_in;
   assign busy  = (state_q != IDLE);
   assign load  = (state_q == IDLE) && start;
   assign run   = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (pos_q == '0) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sum  = '0;
      lodd = '0;
      for (int i = 0; i <= T; i++) begin
         sum = sum ^ term_q[i];
         if (i % 2 == 1) lodd = lodd ^ term_q[i];
      end
   end

   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         term_q    <= '0;
         pos_q     <= '0;
         acc_q     <= '0;
         deg_q     <= '0;
         out_valid <= 1'b0;
         out_pos   <= '0;
         out_err   <= 1'b0;
         out_lodd  <= '0;
         done      <= 1'b0;
         err_cnt   <= '0;
         fail      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            for (int i = 0; i <= T; i++)
               term_q[i] <= gf_mul(lam_w[i], K_LOAD[i]);
            pos_q <= PW'(N - 1);
            acc_q <= '0;
            deg_q <= lambda_deg;
         end else if (run) begin
            for (int i = 0; i <= T; i++)
               term_q[i] <= gf_mul(term_q[i], K_STEP[i]);
            if (pos_q != '0) pos_q <= pos_q - 1'b1;
            if (sum == '0 && acc_q != '1) acc_q <= acc_q + 1'b1;
         end
         out_valid <= run;
         out_err   <= run && (sum == '0);
         if (run) begin
            out_pos  <= pos_q;
            out_lodd <= lodd;
         end
         done <= (state_q == FLUSH);
         if (state_q == FLUSH) begin
            err_cnt <= acc_q;
            fail    <= (acc_q != deg_q) || (int'(deg_q) > T);
         end
      end
   end

endmodule

// File: tb/tb_chien_search_param.sv
// Bench for chien_search_param: vector table plus scoreboard driven by
// an independent log/antilog GF(256) evaluation model.
module tb_chien_search_param;

   typedef logic [8:0][7:0] lam_t;

   typedef struct {
      int   dut;
      lam_t lam;
      int   deg;
      int   ecnt;
      bit   efail;
   } vec_t;

   typedef struct {
      int cyc;
      int pos;
      bit err;
      int lodd;
   } exp_out_t;

   typedef struct {
      int cyc;
      int cnt;
      bit fail;
   } exp_done_t;

   logic       clk_in = 1'b0;
   logic       sys_rst;
   logic       start_a, start_b;
   lam_t       lambda_in;
   logic [3:0] lambda_deg;

   logic       busy_a, valid_a, err_a, done_a, fail_a;
   logic [7:0] pos_a, lodd_a;
   logic [3:0] cnt_a;
   logic       busy_b, valid_b, err_b, done_b, fail_b;
   logic [7:0] pos_b, lodd_b;
   logic [3:0] cnt_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int sel = 0;

   int exp_t [0:509];
   int log_t [0:255];

   exp_out_t  oq[$];
   exp_done_t dq[$];
   exp_out_t  eo;
   exp_done_t ed;
   vec_t      vec[12];

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   chien_search_param #(.N(255)) dut_a (
      .clk_in(clk_in), .sys_rst(sys_rst), .start(start_a),
      .lambda_in(lambda_in), .lambda_deg(lambda_deg),
      .busy(busy_a), .out_valid(valid_a), .out_pos(pos_a),
      .out_err(err_a), .out_lodd(lodd_a), .done(done_a),
      .err_cnt(cnt_a), .fail(fail_a));

   chien_search_param #(.N(204)) dut_b (
      .clk_in(clk_in), .sys_rst(sys_rst), .start(start_b),
      .lambda_in(lambda_in), .lambda_deg(lambda_deg),
      .busy(busy_b), .out_valid(valid_b), .out_pos(pos_b),
      .out_err(err_b), .out_lodd(lodd_b), .done(done_b),
      .err_cnt(cnt_b), .fail(fail_b));

   logic       m_valid, m_err, m_done, m_fail;
   logic [7:0] m_pos, m_lodd;
   logic [3:0] m_cnt;

   always_comb begin
      m_valid = valid_a; m_err = err_a; m_done = done_a;
      m_fail  = fail_a;  m_pos = pos_a; m_lodd = lodd_a;
      m_cnt   = cnt_a;
      if (sel == 1) begin
         m_valid = valid_b; m_err = err_b; m_done = done_b;
         m_fail  = fail_b;  m_pos = pos_b; m_lodd = lodd_b;
         m_cnt   = cnt_b;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                  name, cyc, act, req);
      end
   endtask

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_t[log_t[a] + log_t[b]];
   endfunction

   function automatic lam_t mul_root(input lam_t p, input int r);
      lam_t q;
      q = p;
      for (int i = 1; i <= 8; i++)
         q[i] = p[i] ^ 8'(gmul(exp_t[r], int'(p[i-1])));
      return q;
   endfunction

   // direct evaluation of Lambda(alpha^-p) for every position
   task automatic push_frame(input lam_t lam, input int n, input int s,
                             input int ecnt, input bit efail);
      exp_out_t e;
      exp_done_t d;
      for (int k = 0; k < n; k++) begin
         int p, x, xp, sm, lo, t;
         p  = n - 1 - k;
         x  = exp_t[(255 - p) % 255];
         xp = 1; sm = 0; lo = 0;
         for (int i = 0; i <= 8; i++) begin
            t  = gmul(int'(lam[i]), xp);
            sm = sm ^ t;
            if (i % 2 == 1) lo = lo ^ t;
            xp = gmul(xp, x);
         end
         e.cyc = s + 2 + k; e.pos = p; e.err = (sm == 0); e.lodd = lo;
         oq.push_back(e);
      end
      d.cyc = s + n + 2; d.cnt = ecnt; d.fail = efail;
      dq.push_back(d);
   endtask

   always @(negedge clk_in) begin
      if (m_valid) begin
         if (oq.size() == 0) begin
            chk("out_valid_unexpected", 1, 0);
         end else begin
            eo = oq.pop_front();
            chk("out_cycle", cyc, eo.cyc);
            chk("out_pos", int'(m_pos), eo.pos);
            chk("out_err", int'(m_err), int'(eo.err));
            chk("out_lodd", int'(m_lodd), eo.lodd);
         end
      end
      if (m_done) begin
         if (dq.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            ed = dq.pop_front();
            chk("done_cycle", cyc, ed.cyc);
            chk("err_cnt", int'(m_cnt), ed.cnt);
            chk("fail", int'(m_fail), int'(ed.fail));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic launch(input int v);
      lam_t junk;
      sel        = vec[v].dut;
      lambda_in  = vec[v].lam;
      lambda_deg = 4'(vec[v].deg);
      chk("busy_at_start", int'(sel == 1 ? busy_b : busy_a), 0);
      if (sel == 1) start_b = 1'b1;
      else start_a = 1'b1;
      push_frame(vec[v].lam, (sel == 1) ? 204 : 255, cyc,
                 vec[v].ecnt, vec[v].efail);
      step(1);
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i <= 8; i++) junk[i] = 8'($urandom);
      lambda_in  = junk;
      lambda_deg = 4'($urandom);
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 700; k++) begin
         if (oq.size() == 0 && dq.size() == 0) break;
         step(1);
      end
      if (k == 700) begin
         chk("drain_timeout", oq.size() + dq.size(), 0);
         oq.delete();
         dq.delete();
      end
   endtask

   initial begin
      int   s;
      int   ndone;
      lam_t l;
      int   v;

      v = 1;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = v;
         log_t[v] = i;
         v = v << 1;
         if ((v & 256) != 0) v = v ^ 'h11D;
      end
      for (int i = 0; i < 255; i++) exp_t[i + 255] = exp_t[i];
      log_t[0] = 0;

      l = '0; l[0] = 8'd1;
      vec[0] = '{0, l, 0, 0, 1'b0};
      vec[1] = '{0, mul_root(l, 10), 1, 1, 1'b0};
      vec[2] = '{0, mul_root(mul_root(l, 3), 200), 2, 2, 1'b0};
      l[1] = 8'h01; l[2] = 8'h20;
      vec[3] = '{0, l, 2, 0, 1'b1};
      l = '0; l[0] = 8'd1;
      vec[4] = '{0, mul_root(l, 10), 9, 1, 1'b1};
      vec[5] = '{0, mul_root(l, 10), 2, 1, 1'b1};
      l = '0; l[1] = 8'd1;
      vec[6] = '{0, l, 1, 0, 1'b1};
      l = '0;
      vec[7] = '{0, l, 0, 15, 1'b1};
      l[0] = 8'd1;
      l = mul_root(mul_root(mul_root(mul_root(l, 0), 1), 2), 50);
      l = mul_root(mul_root(mul_root(mul_root(l, 100), 150), 254), 7);
      vec[8] = '{0, l, 8, 8, 1'b0};
      l = '0; l[0] = 8'd1;
      vec[9]  = '{1, mul_root(l, 10), 1, 1, 1'b0};
      vec[10] = '{1, mul_root(mul_root(l, 3), 200), 2, 2, 1'b0};
      vec[11] = '{1, mul_root(l, 230), 1, 0, 1'b1};

      sys_rst    = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      lambda_in  = '0;
      lambda_deg = '0;
      step(3);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_pos", int'(pos_a), 0);
      chk("rst_err", int'(err_a), 0);
      chk("rst_lodd", int'(lodd_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_cnt", int'(cnt_a), 0);
      chk("rst_fail", int'(fail_a), 0);
      chk("rst_busy_b", int'(busy_b), 0);
      sys_rst = 1'b0;
      step(2);

      for (int i = 0; i < 12; i++) begin
         launch(i);
         drain();
         step(2);
      end

      // start mid-frame is ignored; start in the done cycle is taken
      s = cyc;
      launch(1);
      step(49);
      chk("busy_mid_frame", int'(busy_a), 1);
      start_a    = 1'b1;
      lambda_in  = '0;
      lambda_deg = 4'd5;
      step(1);
      start_a = 1'b0;
      step(s + 257 - cyc);
      launch(2);
      drain();
      step(2);

      launch(4);
      drain();
      step(2);

      // reset in the middle of a frame
      s = cyc;
      launch(2);
      step(s + 100 - cyc);
      sys_rst = 1'b1;
      step(1);
      sys_rst = 1'b0;
      oq.delete();
      dq.delete();
      chk("mid_rst_busy", int'(busy_a), 0);
      chk("mid_rst_valid", int'(valid_a), 0);
      chk("mid_rst_cnt", int'(cnt_a), 0);
      chk("mid_rst_fail", int'(fail_a), 0);
      ndone = 0;
      for (int k = 0; k < 300; k++) begin
         step(1);
         if (done_a) ndone++;
      end
      chk("mid_rst_no_done", ndone, 0);
      chk("mid_rst_cnt_hold", int'(cnt_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
